// File: rtl/sprite_blit.sv
// Sprite blitter: streams one sprite out of a shared synchronous ROM and emits
// one clipped, colour-keyed plot per pixel towards the VGA adapter.
module sprite_blit #(
  parameter int                  SPR_W      = 16,
  parameter int                  SPR_H      = 16,
  parameter int                  NUM_SPR    = 2,
  parameter int                  COLOUR_W   = 9,
  parameter int                  X_W        = 8,
  parameter int                  Y_W        = 7,
  parameter int                  SCREEN_W   = 160,
  parameter int                  SCREEN_H   = 120,
  parameter int                  ROM_LAT    = 1,
  parameter int                  TRANSP_EN  = 1,
  parameter logic [COLOUR_W-1:0] TRANSP_COL = '0,
  localparam int NPIX  = SPR_W * SPR_H,
  localparam int SEL_W = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1,
  localparam int A_W   = $clog2(NUM_SPR * NPIX)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [SEL_W-1:0]    sprite_sel,
  input  logic [X_W-1:0]      x_origin,
  input  logic [Y_W-1:0]      y_origin,
  output logic                busy,
  output logic                done,
  output logic [A_W-1:0]      rom_addr,
  input  logic [COLOUR_W-1:0] rom_q,
  output logic                plot,
  output logic [X_W-1:0]      x_out,
  output logic [Y_W-1:0]      y_out,
  output logic [COLOUR_W-1:0] colour_out
);

  localparam int CNT_W = $clog2(NPIX);
  localparam int DRN_W = $clog2(ROM_LAT + 1) + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t               state, state_nx;
  logic [CNT_W-1:0]     cnt;
  logic [DRN_W-1:0]     drn_cnt;
  logic [SEL_W-1:0]     sel_q;
  logic [X_W-1:0]       xo_q;
  logic [Y_W-1:0]       yo_q;

  logic                 issue;
  logic [CNT_W-1:0]     pix_idx;
  logic [SEL_W-1:0]     pix_sel;
  logic [X_W-1:0]       pix_xo;
  logic [Y_W-1:0]       pix_yo;
  logic                 sel_ok;
  logic [X_W:0]         x_sum;
  logic [Y_W:0]         y_sum;
  logic                 in_scr;

  logic [ROM_LAT:0]     vld_p;
  logic [X_W-1:0]       x_p [0:ROM_LAT];
  logic [Y_W-1:0]       y_p [0:ROM_LAT];
  logic                 vis;

  function automatic logic [A_W-1:0] addr_of(input logic [SEL_W-1:0] sel,
                                             input logic [CNT_W-1:0] idx);
    logic [SEL_W+CNT_W-1:0] full;
    full = {sel, idx};
    return full[A_W-1:0];
  endfunction

  function automatic logic is_transp(input logic [COLOUR_W-1:0] c);
    return (TRANSP_EN != 0) && (c == TRANSP_COL);
  endfunction

  assign sel_ok = ({1'b0, sprite_sel} < (SEL_W+1)'(NUM_SPR));

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    pix_idx  = cnt;
    pix_sel  = sel_q;
    pix_xo   = xo_q;
    pix_yo   = yo_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          pix_sel = sprite_sel;
          pix_xo  = x_origin;
          pix_yo  = y_origin;
          pix_idx = '0;
          if (sel_ok) begin
            state_nx = S_FETCH;
            issue    = 1'b1;
          end else begin
            state_nx = S_DONE;
          end
        end
      end
      S_FETCH: begin
        if (cnt == CNT_W'(NPIX - 1)) begin
          state_nx = S_DRAIN;
        end else begin
          issue   = 1'b1;
          pix_idx = cnt + CNT_W'(1);
        end
      end
      S_DRAIN: if (drn_cnt == DRN_W'(ROM_LAT)) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Screen position of the pixel whose address is being issued; one extra bit so nothing wraps
  assign x_sum  = {1'b0, pix_xo} + (X_W+1)'(int'(pix_idx) % SPR_W);
  assign y_sum  = {1'b0, pix_yo} + (Y_W+1)'(int'(pix_idx) / SPR_W);
  assign in_scr = (x_sum < (X_W+1)'(SCREEN_W)) && (y_sum < (Y_W+1)'(SCREEN_H));

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      cnt      <= '0;
      drn_cnt  <= '0;
      rom_addr <= '0;
    end else begin
      state <= state_nx;
      if (issue) begin
        cnt      <= pix_idx;
        rom_addr <= addr_of(pix_sel, pix_idx);
      end
      if (state == S_DRAIN) drn_cnt <= drn_cnt + DRN_W'(1);
      else                  drn_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      sel_q <= sprite_sel;
      xo_q  <= x_origin;
      yo_q  <= y_origin;
    end
  end

  // p0: aligned with rom_addr; p[ROM_LAT]: aligned with rom_q
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) vld_p <= '0;
    else         vld_p <= {vld_p[ROM_LAT-1:0], issue && in_scr};
  end

  always_ff @(posedge clk) begin
    x_p[0] <= x_sum[X_W-1:0];
    y_p[0] <= y_sum[Y_W-1:0];
    for (int k = 1; k <= ROM_LAT; k++) begin
      x_p[k] <= x_p[k-1];
      y_p[k] <= y_p[k-1];
    end
  end

  assign vis = vld_p[ROM_LAT] && !is_transp(rom_q);

  // Output stage: coordinates and colour only move on a real plot
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      plot       <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
    end else begin
      plot <= vis;
      if (vis) begin
        x_out      <= x_p[ROM_LAT];
        y_out      <= y_p[ROM_LAT];
        colour_out <= rom_q;
      end
    end
  end

endmodule

// File: tb/tb_sprite_blit.sv
// Self-checking bench for sprite_blit: two configurations, per-cycle comparison
// against a pixel-level reference model built from the blit rules.
module tb_sprite_blit;

  logic clk, resetn;

  // Instance A: defaults (16x16, 2 sprites, ROM_LAT=1)
  logic       start_a, busy_a, done_a, plot_a;
  logic [0:0] sel_a;
  logic [7:0] xo_a, x_a;
  logic [6:0] yo_a, y_a;
  logic [8:0] addr_a, q_a, col_a;

  // Instance B: 8x4, 3 sprites, ROM_LAT=3
  logic       start_b, busy_b, done_b, plot_b;
  logic [1:0] sel_b;
  logic [7:0] xo_b, x_b;
  logic [6:0] yo_b, y_b;
  logic [6:0] addr_b;
  logic [8:0] q_b, col_b;

  logic [8:0] rom_a [512];
  logic [8:0] rom_b [128];
  logic [8:0] qa1, qb1, qb2, qb3;

  int n_tests = 0;
  int n_fail  = 0;
  int last_x [2];
  int last_y [2];
  int last_c [2];

  sprite_blit u_a (
    .clk(clk), .resetn(resetn), .start(start_a), .sprite_sel(sel_a),
    .x_origin(xo_a), .y_origin(yo_a), .busy(busy_a), .done(done_a),
    .rom_addr(addr_a), .rom_q(q_a), .plot(plot_a), .x_out(x_a),
    .y_out(y_a), .colour_out(col_a)
  );

  sprite_blit #(.SPR_W(8), .SPR_H(4), .NUM_SPR(3), .ROM_LAT(3)) u_b (
    .clk(clk), .resetn(resetn), .start(start_b), .sprite_sel(sel_b),
    .x_origin(xo_b), .y_origin(yo_b), .busy(busy_b), .done(done_b),
    .rom_addr(addr_b), .rom_q(q_b), .plot(plot_b), .x_out(x_b),
    .y_out(y_b), .colour_out(col_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROMs with the latency each instance expects
  always @(posedge clk) begin
    qa1 <= rom_a[addr_a];
    qb1 <= rom_b[addr_b];
    qb2 <= qb1;
    qb3 <= qb2;
  end
  assign q_a = qa1;
  assign q_b = qb3;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive(input int inst, input bit st, input int sel, input int xo, input int yo);
    if (inst == 0) begin
      start_a = st; sel_a = 1'(sel); xo_a = 8'(xo); yo_a = 7'(yo);
    end else begin
      start_b = st; sel_b = 2'(sel); xo_b = 8'(xo); yo_b = 7'(yo);
    end
  endtask

  // One blit: start in cycle 0, watch cycles 1..done(+1). stray = cycle with an
  // extra start pulse; chain = leave start high in the done cycle and return there.
  task automatic blit(input int inst, input int sel, input int xo, input int yo,
                      input int stray, input bit chain, output int n_plot, output int done_at);
    int sw, np, ns, lat, done_c, last_n, i, x, y, c, bad, bad_addr, e_addr;
    logic e_plot, e_busy, e_done, valid;
    logic o_plot, o_busy, o_done;
    logic [7:0] o_x, o_y;
    logic [8:0] o_c, o_addr, addr0;
    logic [63:0] act, exp, f_act, f_exp;
    sw  = (inst == 0) ? 16 : 8;
    np  = (inst == 0) ? 256 : 32;
    ns  = (inst == 0) ? 2 : 3;
    lat = (inst == 0) ? 1 : 3;
    valid  = (sel < ns);
    done_c = valid ? lat + 2 + np : 1;
    last_n = chain ? done_c : done_c + 1;
    n_plot = 0; done_at = -1; bad = 0; bad_addr = 0;
    f_act = '0; f_exp = '0;
    @(negedge clk);
    addr0 = (inst == 0) ? addr_a : 9'(addr_b);
    drive(inst, 1'b1, sel, xo, yo);
    for (int n = 1; n <= last_n; n++) begin
      @(negedge clk);
      if (inst == 0) begin
        o_plot = plot_a; o_busy = busy_a; o_done = done_a; o_x = x_a;
        o_y = {1'b0, y_a}; o_c = col_a; o_addr = addr_a;
      end else begin
        o_plot = plot_b; o_busy = busy_b; o_done = done_b; o_x = x_b;
        o_y = {1'b0, y_b}; o_c = col_b; o_addr = {2'b00, addr_b};
      end
      e_plot = 1'b0;
      if (valid) begin
        i = n - lat - 2;
        if (i >= 0 && i < np) begin
          x = xo + i % sw;
          y = yo + i / sw;
          c = (inst == 0) ? int'(rom_a[sel*np + i]) : int'(rom_b[sel*np + i]);
          if (x < 160 && y < 120 && c != 0) begin
            e_plot = 1'b1;
            last_x[inst] = x; last_y[inst] = y; last_c[inst] = c;
          end
        end
      end
      e_busy = (n <= done_c);
      e_done = (n == done_c);
      act = 64'({o_plot, o_busy, o_done, o_x, o_y, o_c});
      exp = 64'({e_plot, e_busy, e_done, 8'(last_x[inst]), 8'(last_y[inst]), 9'(last_c[inst])});
      if (act !== exp && bad == 0) begin f_act = act; f_exp = exp; end
      if (act !== exp) bad++;
      if (bad == 0) begin f_act = act; f_exp = exp; end
      if (valid && n <= np) begin
        e_addr = sel*np + n - 1;
        if (o_addr !== 9'(e_addr)) bad_addr++;
      end else if (!valid) begin
        if (o_addr !== addr0) bad_addr++;
      end
      if (o_plot === 1'b1) n_plot++;
      if (o_done === 1'b1 && done_at < 0) done_at = n;
      drive(inst, (n == stray) || (chain && n == done_c),
            $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 127));
    end
    check("cycle_vec", f_act, f_exp);
    check("cycle_mism", 64'(bad), 64'd0);
    check("addr_mism", 64'(bad_addr), 64'd0);
    check("done_cycle", 64'(done_at), 64'(done_c));
  endtask

  int np_o, d_o, cnt_p, cnt_d;

  initial begin
    for (int k = 0; k < 512; k++) rom_a[k] = 9'($urandom_range(1, 511));
    for (int k = 0; k < 128; k++) rom_b[k] = 9'($urandom_range(1, 511));
    for (int k = 0; k < 2; k++) begin last_x[k] = 0; last_y[k] = 0; last_c[k] = 0; end
    resetn = 1'b0;
    drive(0, 1'b0, 0, 0, 0);
    drive(1, 1'b0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_a", 64'({plot_a, busy_a, done_a, x_a, y_a, col_a, addr_a}), 64'd0);
    check("rst_b", 64'({plot_b, busy_b, done_b, x_b, y_b, col_b, addr_b}), 64'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Sprite 1 at (10,20): full 256-pixel blit
    blit(0, 1, 10, 20, -1, 1'b0, np_o, d_o);
    check("t1_nplots", 64'(np_o), 64'd256);
    check("t1_done", 64'(d_o), 64'd259);

    // Transparent first row of sprite 0
    for (int k = 0; k < 16; k++) rom_a[k] = 9'h000;
    blit(0, 0, 10, 20, -1, 1'b0, np_o, d_o);
    check("t2_nplots", 64'(np_o), 64'd240);
    check("t2_done", 64'(d_o), 64'd259);

    // Clipped at the bottom-right corner
    blit(0, 1, 150, 115, -1, 1'b0, np_o, d_o);
    check("t3_nplots", 64'(np_o), 64'd50);

    // Latency 3, stray starts in cycle 10 and the done cycle, restart right after
    blit(1, 1, 20, 30, 10, 1'b1, np_o, d_o);
    check("t4_nplots", 64'(np_o), 64'd32);
    check("t4_done", 64'(d_o), 64'd37);
    blit(1, 2, 100, 50, -1, 1'b0, np_o, d_o);
    check("t4_restart_nplots", 64'(np_o), 64'd32);

    // Out-of-range sprite index
    blit(1, 3, 40, 40, -1, 1'b0, np_o, d_o);
    check("t5_nplots", 64'(np_o), 64'd0);
    check("t5_done", 64'(d_o), 64'd1);

    // Asynchronous reset in mid-blit
    @(negedge clk);
    drive(0, 1'b1, 1, 10, 20);
    @(negedge clk);
    drive(0, 1'b0, 0, 0, 0);
    repeat (99) @(negedge clk);
    #1 resetn = 1'b0;
    #1 check("rst_mid", 64'({plot_a, busy_a, done_a, x_a, y_a, col_a, addr_a}), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 2; k++) begin last_x[k] = 0; last_y[k] = 0; last_c[k] = 0; end
    cnt_p = 0; cnt_d = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (plot_a !== 1'b0) cnt_p++;
      if (done_a !== 1'b0 || busy_a !== 1'b0) cnt_d++;
    end
    check("rst_noplot", 64'(cnt_p), 64'd0);
    check("rst_nodone", 64'(cnt_d), 64'd0);

    // Randomized blits with sprinkled transparent pixels
    for (int k = 0; k < 40; k++) rom_a[$urandom_range(0, 511)] = 9'h000;
    for (int k = 0; k < 12; k++) rom_b[$urandom_range(0, 95)] = 9'h000;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0)
        blit(0, $urandom_range(0, 1), $urandom_range(0, 159), $urandom_range(0, 119),
             $urandom_range(2, 250), 1'b0, np_o, d_o);
      else
        blit(0, $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 127),
             -1, 1'b0, np_o, d_o);
    end
    for (int k = 0; k < 6; k++)
      blit(1, $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 127),
           $urandom_range(2, 30), 1'b0, np_o, d_o);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
